uart_rx_byte: RTL and testbench

//  RS-232 serial receiver: recovers 8N1 frames from asynchronous rxd_i and emits each byte as a
//  1-cycle write strobe. Sits directly upstream of the 8-to-32 byte-packing FIFO.
//  rx_data_o/rx_wr_o connect to the FIFO's wdata_i/wr_i; the FIFO full flag returns on full_i.

---
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 tb/tb_uart_rx_byte.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: oversamples rxd_i with a bit-timing counter and hands each good byte
// to the downstream packing FIFO as a one-cycle write, flagging framing errors and overruns.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       sclk,
    input  logic       rstn,
    input  logic       rxd_i,
    input  logic       full_i,
    input  logic       clr_err_i,
    output logic [7:0] rx_data_o,
    output logic       rx_wr_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       data_n;
    logic             wr_n, set_fe, set_ov;
    logic             sync1, rxd_s;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            sync1       <= 1'b1;
            rxd_s       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_data_o   <= '0;
            rx_wr_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            sync1     <= rxd_i;
            rxd_s     <= sync1;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            rx_data_o <= data_n;
            rx_wr_o   <= wr_n;
            // A set event in the same cycle as a clear takes priority.
            if (set_fe)
                frame_err_o <= 1'b1;
            else if (clr_err_i)
                frame_err_o <= 1'b0;
            if (set_ov)
                overrun_o <= 1'b1;
            else if (clr_err_i)
                overrun_o <= 1'b0;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        data_n    = rx_data_o;
        wr_n      = 1'b0;
        set_fe    = 1'b0;
        set_ov    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s)
                    state_n = START;
            end
            START: begin
                // Re-check the start bit at its midpoint to reject short glitches.
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shreg_n   = {rxd_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        state_n = IDLE;
                        if (full_i) begin
                            set_ov = 1'b1;
                        end else begin
                            wr_n   = 1'b1;
                            data_n = shreg;
                        end
                    end else begin
                        set_fe  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxd_s)
                    state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed and randomized frame stimulus for uart_rx_byte; received bytes are collected by a
// monitor and compared with a frame-level model of which bytes and flags should result.
module tb_uart_rx_byte;

    localparam int CPB = 8;

    logic       sclk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd_i = 1'b1;
    logic       full_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_wr_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .sclk        (sclk),
        .rstn        (rstn),
        .rxd_i       (rxd_i),
        .full_i      (full_i),
        .clr_err_i   (clr_err_i),
        .rx_data_o   (rx_data_o),
        .rx_wr_o     (rx_wr_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 sclk = ~sclk;

    // Stands in for the FIFO: every write strobe deposits one byte.
    always @(negedge sclk) begin
        if (rx_wr_o)
            rx_q.push_back(rx_data_o);
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_i = bits[i];
            wait_cycles(CPB);
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        check_output({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_output({tag, "_byte"}, {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_data"}, {24'h0, rx_data_o}, 32'h0);
        check_output({tag, "_wr"}, {31'h0, rx_wr_o}, 32'h0);
        check_output({tag, "_ferr"}, {31'h0, frame_err_o}, 32'h0);
        check_output({tag, "_ovr"}, {31'h0, overrun_o}, 32'h0);
        check_output({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    endtask

    task automatic pulse_clear();
        clr_err_i = 1'b1;
        wait_cycles(1);
        clr_err_i = 1'b0;
        wait_cycles(1);
    endtask

    initial begin
        logic [31:0] word;
        logic [7:0]  d;
        logic        stop, full, exp_fe, exp_ov;

        @(negedge sclk);
        wait_cycles(3);
        check_idle_outputs("reset");
        rstn = 1'b1;
        wait_cycles(4);

        $display("[TB] single byte 0xA5");
        send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'hA5);
        wait_cycles(4);
        check_stream("t1");
        check_output("t1_ferr", {31'h0, frame_err_o}, 32'h0);
        check_output("t1_ovr", {31'h0, overrun_o}, 32'h0);
        check_output("t1_busy", {31'h0, busy_o}, 32'h0);

        $display("[TB] back-to-back frames");
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_cycles(4);
        check_output("t2_count", rx_q.size(), 32'd4);
        word = '0;
        if (rx_q.size() >= 4)
            word = {rx_q[3], rx_q[2], rx_q[1], rx_q[0]};
        check_output("t2_word", word, 32'h34333231);
        rx_q.delete();

        $display("[TB] overrun with FIFO full");
        full_i = 1'b1;
        send_frame(8'h55, 1'b1);
        wait_cycles(4);
        full_i = 1'b0;
        check_stream("t3");
        check_output("t3_ovr_set", {31'h0, overrun_o}, 32'h1);
        check_output("t3_ferr", {31'h0, frame_err_o}, 32'h0);
        pulse_clear();
        check_output("t3_ovr_clr", {31'h0, overrun_o}, 32'h0);

        $display("[TB] framing error and break");
        send_frame(8'h3C, 1'b0);
        wait_cycles(40);
        check_output("t4_busy_low", {31'h0, busy_o}, 32'h1);
        check_output("t4_ferr", {31'h0, frame_err_o}, 32'h1);
        check_stream("t4a");
        rxd_i = 1'b1;
        wait_cycles(4);
        check_output("t4_busy_idle", {31'h0, busy_o}, 32'h0);
        send_frame(8'h0F, 1'b1);
        exp_q.push_back(8'h0F);
        wait_cycles(4);
        check_stream("t4b");
        pulse_clear();
        check_output("t4_ferr_clr", {31'h0, frame_err_o}, 32'h0);

        $display("[TB] short glitch");
        rxd_i = 1'b0;
        wait_cycles(2);
        rxd_i = 1'b1;
        wait_cycles(8);
        check_output("t5_busy", {31'h0, busy_o}, 32'h0);
        check_output("t5_ferr", {31'h0, frame_err_o}, 32'h0);
        check_output("t5_ovr", {31'h0, overrun_o}, 32'h0);
        check_stream("t5");

        $display("[TB] reset mid-frame");
        rxd_i = 1'b0;
        wait_cycles(CPB);
        rxd_i = 1'b1;
        wait_cycles(4 * CPB + 4);
        rstn = 1'b0;
        wait_cycles(2);
        check_idle_outputs("t6_rst");
        rstn = 1'b1;
        wait_cycles(4 * CPB);
        check_stream("t6a");
        send_frame(8'h81, 1'b1);
        exp_q.push_back(8'h81);
        wait_cycles(4);
        check_stream("t6b");

        $display("[TB] randomized frames");
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            full = ($urandom_range(0, 3) == 0);
            full_i = full;
            send_frame(d, stop);
            rxd_i = 1'b1;
            if (stop && !full)
                exp_q.push_back(d);
            if (stop && full)
                exp_ov = 1'b1;
            if (!stop)
                exp_fe = 1'b1;
            wait_cycles(stop ? $urandom_range(0, 3) : $urandom_range(4, 8));
        end
        full_i = 1'b0;
        wait_cycles(4);
        check_stream("rnd");
        check_output("rnd_ferr", {31'h0, frame_err_o}, {31'h0, exp_fe});
        check_output("rnd_ovr", {31'h0, overrun_o}, {31'h0, exp_ov});
        check_output("rnd_busy", {31'h0, busy_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
